// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: multi-channel serial audio transmitter (I2S / left-justified, stereo / TDM).
// A frame of CHANNELS*SLOT_W bit periods is shifted out MSB first on d, with bit clock sck,
// word select / frame sync lr, and a free-running master clock mck. One frame of samples is
// buffered in a holding register filled through a valid/ready handshake. When the holding
// register is empty at the load point, the previous frame is repeated and underrun pulses.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   enable                  run serial output (sampled at frame boundary)
//   sample_valid/ready      handshake for sample_data (ch0 in the MSBs)
//   sample_data             CHANNELS*DATA_W bits, two's complement samples
//   mck, sck, lr, d         codec DAC pins
//   frame_start, underrun   one-clock status pulses at the frame load point
module i2s_tx_multi #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned SCK_DIV  = 8,
  parameter int unsigned MCK_DIV  = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic [CHANNELS*DATA_W-1:0]   sample_data,
  output logic                         mck,
  output logic                         sck,
  output logic                         lr,
  output logic                         d,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int unsigned FRAME_BITS = CHANNELS * SLOT_W;
  localparam int unsigned POS_W      = $clog2(FRAME_BITS);
  localparam int unsigned SCK_W      = $clog2(SCK_DIV);
  localparam int unsigned MCK_W      = (MCK_DIV > 1) ? $clog2(MCK_DIV) : 1;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] LOAD_POS = (MODE == 0) ? POS_W'(1) : '0;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                        state, state_next;
  logic [MCK_W-1:0]              mck_cnt;
  logic [SCK_W-1:0]              sck_cnt;
  logic [POS_W-1:0]              pos;
  logic [CHANNELS*DATA_W-1:0]    hold;
  logic [CHANNELS*DATA_W-1:0]    last_frame;
  logic                          hold_full;
  logic [FRAME_BITS-1:0]         sreg;

  logic                          sck_wrap;
  logic                          start_evt, rise_evt, fall_evt, stop_evt, step_evt, load_evt;
  logic [POS_W-1:0]              pos_next;
  logic                          lr_next;
  logic                          accept, hold_full_next;
  logic [CHANNELS*DATA_W-1:0]    load_src;
  logic [FRAME_BITS-1:0]         load_bits;

  // Place each channel's DATA_W bits at the top of its slot, zero padding below.
  function automatic logic [FRAME_BITS-1:0] expand(input logic [CHANNELS*DATA_W-1:0] raw);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      for (int unsigned b = 0; b < DATA_W; b++) begin
        f[FRAME_BITS-1-ch*SLOT_W-b] = raw[CHANNELS*DATA_W-1-ch*DATA_W-b];
      end
    end
    return f;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_evt) state_next = ST_RUN;
      ST_RUN:  if (stop_evt)  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Event / output decode. A start acts as a falling edge entering pos 0 with sck already low.
  always_comb begin
    sck_wrap  = (sck_cnt == SCK_W'(SCK_DIV - 1));
    start_evt = (state == ST_IDLE) && sck_wrap && enable;
    rise_evt  = (state == ST_RUN) && sck_wrap && !sck;
    fall_evt  = (state == ST_RUN) && sck_wrap && sck;
    stop_evt  = fall_evt && (pos == LAST_POS) && !enable;
    step_evt  = start_evt || (fall_evt && !stop_evt);
    if (start_evt || pos == LAST_POS) pos_next = '0;
    else                              pos_next = pos + POS_W'(1);
    if (CHANNELS == 2) lr_next = (pos_next >= POS_W'(SLOT_W));
    else               lr_next = (pos_next == '0);
    load_evt       = step_evt && (pos_next == LOAD_POS);
    load_src       = hold_full ? hold : last_frame;
    load_bits      = expand(load_src);
    accept         = sample_valid && sample_ready;
    hold_full_next = hold_full;
    if (load_evt && hold_full) hold_full_next = 1'b0;
    else if (accept)           hold_full_next = 1'b1;
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      mck_cnt      <= '0;
      mck          <= 1'b0;
      sck_cnt      <= '0;
      sck          <= 1'b0;
      pos          <= '0;
      lr           <= 1'b0;
      d            <= 1'b0;
      sreg         <= '0;
      hold         <= '0;
      last_frame   <= '0;
      hold_full    <= 1'b0;
      sample_ready <= 1'b0;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      if (mck_cnt == MCK_W'(MCK_DIV - 1)) begin
        mck_cnt <= '0;
        mck     <= ~mck;
      end else begin
        mck_cnt <= mck_cnt + MCK_W'(1);
      end
      sck_cnt      <= sck_wrap ? '0 : sck_cnt + SCK_W'(1);
      frame_start  <= load_evt;
      underrun     <= load_evt && !hold_full;
      hold_full    <= hold_full_next;
      sample_ready <= !hold_full_next;
      if (accept)   hold       <= sample_data;
      if (load_evt) last_frame <= load_src;
      if (rise_evt) sck <= 1'b1;
      if (stop_evt) begin
        sck  <= 1'b0;
        pos  <= '0;
        lr   <= 1'b0;
        d    <= 1'b0;
        sreg <= '0;
      end else if (step_evt) begin
        sck <= 1'b0;
        pos <= pos_next;
        lr  <= lr_next;
        // In I2S mode pos 0 still shifts out the final bit of the previous frame.
        if (load_evt) begin
          d    <= load_bits[FRAME_BITS-1];
          sreg <= load_bits << 1;
        end else begin
          d    <= sreg[FRAME_BITS-1];
          sreg <= sreg << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// Self-checking bench for i2s_tx_multi: a stereo I2S instance and an 8-channel TDM
// left-justified instance, driven with random handshake traffic, enable gaps and a
// mid-frame reset, compared every clock against a time-based reference model.
module tb_i2s_tx_multi;

  localparam int DW [2] = '{16, 24};
  localparam int SL [2] = '{16, 32};
  localparam int CH [2] = '{2, 8};
  localparam int SD [2] = '{4, 2};
  localparam int MD [2] = '{2, 2};
  localparam int MO [2] = '{0, 1};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, enable, valid0, valid1;
  logic [31:0]  data0;
  logic [191:0] data1;
  logic         rdy0, mck0, sck0, lr0, d0, fs0, ur0;
  logic         rdy1, mck1, sck1, lr1, d1, fs1, ur1;
  logic [6:0]   out0, out1;

  assign out0 = {mck0, sck0, lr0, d0, fs0, ur0, rdy0};
  assign out1 = {mck1, sck1, lr1, d1, fs1, ur1, rdy1};

  i2s_tx_multi #(.DATA_W(16), .SLOT_W(16), .CHANNELS(2), .SCK_DIV(4), .MCK_DIV(2), .MODE(0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .sample_valid(valid0), .sample_ready(rdy0),
    .sample_data(data0), .mck(mck0), .sck(sck0), .lr(lr0), .d(d0),
    .frame_start(fs0), .underrun(ur0));

  i2s_tx_multi #(.DATA_W(24), .SLOT_W(32), .CHANNELS(8), .SCK_DIV(2), .MCK_DIV(2), .MODE(1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .sample_valid(valid1), .sample_ready(rdy1),
    .sample_data(data1), .mck(mck1), .sck(sck1), .lr(lr1), .d(d1),
    .frame_start(fs1), .underrun(ur1));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  string nm [7] = '{"mck", "sck", "lr", "d", "frame_start", "underrun", "sample_ready"};

  // Reference model state, per instance
  int           n [2];
  int           t0 [2];
  bit           run [2];
  bit           hfull [2];
  logic [255:0] hold_f [2];
  logic [255:0] last_f [2];
  logic [255:0] cur_f [2];
  bit e_mck [2], e_sck [2], e_lr [2], e_d [2], e_fs [2], e_ur [2], e_rdy [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [255:0] expand(input int i, input logic [255:0] raw);
    logic [255:0] f;
    int fb;
    f  = '0;
    fb = CH[i] * SL[i];
    for (int ch = 0; ch < CH[i]; ch++)
      for (int b = 0; b < DW[i]; b++)
        f[fb-1-ch*SL[i]-b] = raw[CH[i]*DW[i]-1-ch*DW[i]-b];
    return f;
  endfunction

  // Bit period b of the current run has just begun (sck falling edge, or the run start).
  task automatic boundary(input int i, input int b);
    int fb, p, lp;
    fb = CH[i] * SL[i];
    p  = b % fb;
    lp = (MO[i] == 0) ? 1 : 0;
    e_sck[i] = 1'b0;
    e_lr[i]  = (CH[i] == 2) ? (p >= SL[i]) : (p == 0);
    if (p == lp) begin
      if (hfull[i]) begin
        cur_f[i]  = hold_f[i];
        last_f[i] = hold_f[i];
        hfull[i]  = 1'b0;
      end else begin
        cur_f[i] = last_f[i];
        e_ur[i]  = 1'b1;
      end
      e_fs[i] = 1'b1;
    end
    if (MO[i] == 1)  e_d[i] = cur_f[i][fb-1-p];
    else if (p == 0) e_d[i] = (b == 0) ? 1'b0 : cur_f[i][0];
    else             e_d[i] = cur_f[i][fb-p];
  endtask

  // Advance the model over one clock edge with the inputs that were applied at that edge.
  task automatic model_step(input int i, input bit rst, input bit en, input bit vld,
                            input logic [255:0] raw);
    int k, b, fb;
    bit acc;
    fb = CH[i] * SL[i];
    if (rst) begin
      n[i] = 0; t0[i] = 0; run[i] = 0; hfull[i] = 0;
      hold_f[i] = '0; last_f[i] = '0; cur_f[i] = '0;
      e_mck[i] = 0; e_sck[i] = 0; e_lr[i] = 0; e_d[i] = 0;
      e_fs[i] = 0; e_ur[i] = 0; e_rdy[i] = 0;
      return;
    end
    e_fs[i]  = 1'b0;
    e_ur[i]  = 1'b0;
    acc      = vld && e_rdy[i];
    e_mck[i] = (((n[i] + 1) / MD[i]) % 2) == 1;
    if (n[i] % SD[i] == SD[i] - 1) begin
      if (!run[i]) begin
        if (en) begin
          run[i] = 1'b1;
          t0[i]  = n[i];
          boundary(i, 0);
        end
      end else begin
        k = (n[i] - t0[i]) / SD[i];
        if (k % 2 == 1) begin
          e_sck[i] = 1'b1;
        end else begin
          b = k / 2;
          if (b % fb == 0 && !en) begin
            run[i] = 1'b0;
            e_sck[i] = 1'b0; e_lr[i] = 1'b0; e_d[i] = 1'b0;
          end else begin
            boundary(i, b);
          end
        end
      end
    end
    if (acc) begin
      hold_f[i] = expand(i, raw);
      hfull[i]  = 1'b1;
    end
    e_rdy[i] = !hfull[i];
    n[i]++;
  endtask

  task automatic compare(input int i);
    logic [6:0] ov, ev;
    ov = (i == 0) ? out0 : out1;
    ev = {e_mck[i], e_sck[i], e_lr[i], e_d[i], e_fs[i], e_ur[i], e_rdy[i]};
    for (int j = 0; j < 7; j++)
      check($sformatf("dut%0d.%s", i, nm[j]), 64'(ov[6-j]), 64'(ev[6-j]));
  endtask

  task automatic cycle(input bit rst_v, input bit en_v, input int vprob, input bit directed);
    logic [191:0] tdm_pat;
    tdm_pat = {24'h800001, 24'h7FFFFE, 24'h123456, 24'hABCDEF,
               24'h000001, 24'hFFFFFF, 24'h555555, 24'hAAAAAA};
    reset  = rst_v;
    enable = en_v;
    if (directed) begin
      valid0 = 1'b1; data0 = 32'h8001_7FFE;
      valid1 = 1'b1; data1 = tdm_pat;
    end else begin
      valid0 = ($urandom_range(0, 99) < vprob);
      valid1 = ($urandom_range(0, 99) < vprob);
      data0  = $urandom;
      data1  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clock);
    #1;
    cyc++;
    model_step(0, rst_v, en_v, valid0, {224'b0, data0});
    model_step(1, rst_v, en_v, valid1, {64'b0, data1});
    compare(0);
    compare(1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; valid0 = 1'b0; valid1 = 1'b0; data0 = '0; data1 = '0;
    repeat (4)    cycle(1'b1, 1'b1, 0, 1'b0);
    cycle(1'b0, 1'b1, 0, 1'b1);
    repeat (3000) cycle(1'b0, 1'b1, 3, 1'b0);
    repeat (2600) cycle(1'b0, 1'b1, 0, 1'b0);
    repeat (2100) cycle(1'b0, 1'b0, 5, 1'b0);
    repeat (3000) cycle(1'b0, 1'b1, 2, 1'b0);
    repeat (300)  cycle(1'b0, 1'b1, 50, 1'b0);
    repeat (2)    cycle(1'b1, 1'b1, 50, 1'b0);
    repeat (1500) cycle(1'b0, 1'b1, 1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
